mdu_ctrl: RTL

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_arith.sv | 53 +++++
 rtl/mdu_ctrl.sv | 88 ++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and
// the busy-counter width.
package mdu_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU arithmetic: 64-bit signed/unsigned product and
// quotient/remainder packed as {hi,lo}, plus a divide-by-zero flag.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] result,
  output logic        div_zero
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] mag_a;
  logic        [31:0] mag_b;
  logic        [31:0] q_mag;
  logic        [31:0] r_mag;
  logic        [31:0] quot;
  logic        [31:0] rem;
  logic               neg_a;
  logic               neg_b;
  logic               is_div;

  always_comb begin
    is_div   = (op == MDU_DIV) || (op == MDU_DIVU);
    div_zero = is_div && (rt == 32'd0);

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly
    // to 0x80000000 instead of overflowing.
    neg_a = (op == MDU_DIV) && rs[31];
    neg_b = (op == MDU_DIV) && rt[31];
    mag_a = neg_a ? (~rs + 32'd1) : rs;
    mag_b = neg_b ? (~rt + 32'd1) : rt;
    q_mag = (rt == 32'd0) ? 32'd0 : (mag_a / mag_b);
    r_mag = (rt == 32'd0) ? 32'd0 : (mag_a % mag_b);
    quot  = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
    rem   = neg_a ? (~r_mag + 32'd1) : r_mag;

    prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    prod_u = {32'd0, rs} * {32'd0, rt};

    result = 64'd0;
    case (op)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV,
      MDU_DIVU:  result = {rem, quot};
      default:   result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MDU controller: issues mult/div, holds busy for a fixed
// number of cycles, then commits the pending result into HI/LO.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  mdu_state_e       state;
  mdu_state_e       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      pending;
  logic             pend_wr;
  logic [63:0]      arith_res;
  logic             div_zero;
  logic             is_md;
  logic             is_div;
  logic             issue;

  mdu_arith u_arith (
    .op       (op),
    .rs       (rs),
    .rt       (rt),
    .result   (arith_res),
    .div_zero (div_zero)
  );

  assign is_div = (op == MDU_DIV) || (op == MDU_DIVU);
  assign is_md  = (op == MDU_MULT) || (op == MDU_MULTU) || is_div;
  assign issue  = start && (state == ST_IDLE);
  assign busy   = (state == ST_RUN);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start && is_md) state_nx = ST_RUN;
      ST_RUN:  if (cnt == '0) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pending <= 64'd0;
      pend_wr <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      state <= state_nx;
      if (issue) begin
        if (is_md) begin
          pending <= arith_res;
          // A divide by zero still occupies the unit but never commits.
          pend_wr <= !div_zero;
          cnt     <= is_div ? DIV_LOAD : MULT_LOAD;
        end else if (op == MDU_MTHI) begin
          hi <= rs;
        end else if (op == MDU_MTLO) begin
          lo <= rs;
        end
      end else if (state == ST_RUN) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else if (pend_wr) begin
          hi <= pending[63:32];
          lo <= pending[31:0];
        end
      end
    end
  end

endmodule
